// File: rtl/morse_pkg.sv
// Shared Morse symbol constants, digit patterns and decoder state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package morse_pkg;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int DASH_MIN_DEF = 8;
    localparam int GAP_MIN_DEF  = 12;
    localparam int CNT_W_DEF    = 8;

    // Index is the digit value; first symbol sits at bit 4.
    localparam logic [4:0] DIGIT_PAT [10] = '{
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE
    } state_t;

endpackage

// File: rtl/decodificador_if.sv
// Keyed-line input and decoded digit outputs of the Morse decoder.
// Latency: n/a (wiring only).
// Backpressure: none; ready/error are single-cycle strobes with no acknowledge.
interface decodificador_if;
    logic key;
    logic a;
    logic b;
    logic c;
    logic d;
    logic ready;
    logic error;

    modport master (output key, input a, b, c, d, ready, error);
    modport slave  (input key, output a, b, c, d, ready, error);
endinterface

// File: rtl/morse_pattern_lookup.sv
// Maps a 5-symbol Morse pattern to its decimal digit, flagging unknown patterns.
// Latency: combinational.
// Backpressure: n/a.
module morse_pattern_lookup
    import morse_pkg::*;
(
    input  logic [4:0] pattern,
    output logic [3:0] digit,
    output logic       hit
);

    always_comb begin
        digit = 4'd0;
        hit   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pattern == DIGIT_PAT[i]) begin
                digit = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decodificador.sv
// Times marks on a keyed line into dots/dashes and decodes 5-symbol Morse digits.
// Latency: ready/error registered on the edge sampling the low that ends the 5th mark.
// Backpressure: none; strobes are one cycle and the digit holds until the next good decode.
module decodificador
    import morse_pkg::*;
#(
    parameter int DASH_MIN = DASH_MIN_DEF,
    parameter int GAP_MIN  = GAP_MIN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    decodificador_if.slave  bus
);

    state_t             state;
    logic [CNT_W-1:0]   mark_cnt;
    logic [CNT_W-1:0]   space_cnt;
    logic [2:0]         sym_cnt;
    logic [4:0]         pattern;
    logic [3:0]         digit_q;
    logic               ready_q;
    logic               error_q;

    logic               sym;
    logic [4:0]         next_pat;
    logic               mark_sat;
    logic               gap_hit;
    logic [3:0]         lut_digit;
    logic               lut_hit;

    always_comb begin
        sym      = (mark_cnt >= CNT_W'(DASH_MIN)) ? SYM_DASH : SYM_DOT;
        next_pat = {pattern[3:0], sym};
        mark_sat = &mark_cnt;
        gap_hit  = (space_cnt == CNT_W'(GAP_MIN - 1));
    end

    morse_pattern_lookup u_lookup (
        .pattern (next_pat),
        .digit   (lut_digit),
        .hit     (lut_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mark_cnt  <= '0;
            space_cnt <= '0;
            sym_cnt   <= '0;
            pattern   <= '0;
            digit_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.key) begin
                        state    <= ST_MARK;
                        mark_cnt <= CNT_W'(1);
                    end
                end
                ST_MARK: begin
                    if (bus.key) begin
                        if (!mark_sat) mark_cnt <= mark_cnt + 1'b1;
                    end else if (sym_cnt == 3'd4) begin
                        // Fifth symbol: decode straight from the shifted pattern.
                        if (lut_hit) begin
                            digit_q <= lut_digit;
                            ready_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        sym_cnt <= '0;
                        pattern <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        pattern   <= next_pat;
                        sym_cnt   <= sym_cnt + 1'b1;
                        space_cnt <= CNT_W'(1);
                        state     <= ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (bus.key) begin
                        state    <= ST_MARK;
                        mark_cnt <= CNT_W'(1);
                    end else if (gap_hit) begin
                        error_q   <= 1'b1;
                        sym_cnt   <= '0;
                        pattern   <= '0;
                        space_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        space_cnt <= space_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a     = digit_q[3];
    assign bus.b     = digit_q[2];
    assign bus.c     = digit_q[1];
    assign bus.d     = digit_q[0];
    assign bus.ready = ready_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_decodificador.sv
// Scoreboard bench for decodificador: stimulus tasks queue the expected strobe,
// a negedge monitor pops and compares cycle, strobe kind and digit.
module tb_decodificador;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decodificador_if dif ();

    decodificador #(
        .DASH_MIN (8),
        .GAP_MIN  (12),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    typedef struct {
        int         cyc;
        bit         rdy;
        logic [3:0] dig;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [3:0] last_good = 4'd0;
    logic [4:0] pats [10] = '{
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int exp_digit(input logic [4:0] p);
        case (p)
            5'b11111: return 0;
            5'b01111: return 1;
            5'b00111: return 2;
            5'b00011: return 3;
            5'b00001: return 4;
            5'b00000: return 5;
            5'b10000: return 6;
            5'b11000: return 7;
            5'b11100: return 8;
            5'b11110: return 9;
            default:  return -1;
        endcase
    endfunction

    task automatic tick(input bit v);
        dif.key = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input bit rdy, input logic [3:0] dig);
        exp_t e;
        e.cyc = cyc;
        e.rdy = rdy;
        e.dig = dig;
        sb.push_back(e);
    endtask

    // Marks separated by 3 lows; 'gap' lows follow the final mark.
    task automatic send_char(input logic [4:0] pat, input int dot_len,
                             input int dash_len, input int gap);
        int d;
        for (int i = 0; i < 5; i++) begin
            repeat (pat[4-i] ? dash_len : dot_len) tick(1'b1);
            tick(1'b0);
            if (i == 4) begin
                d = exp_digit(pat);
                if (d >= 0) begin
                    last_good = 4'(d);
                    expect_pulse(1'b1, 4'(d));
                end else begin
                    expect_pulse(1'b0, last_good);
                end
                repeat (gap - 1) tick(1'b0);
            end else begin
                repeat (2) tick(1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("missed_pulse_cycle", cyc, e.cyc);
            end
            if (dif.ready || dif.error) begin
                check("ready_error_excl", int'(dif.ready & dif.error), 0);
                if (sb.size() == 0) begin
                    check("spurious_pulse", int'({dif.ready, dif.error}), 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("ready", int'(dif.ready), int'(e.rdy));
                    check("error", int'(dif.error), int'(!e.rdy));
                    check("abcd", int'({dif.a, dif.b, dif.c, dif.d}), int'(e.dig));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with key toggling: outputs must sit at zero.
        reset   = 1'b1;
        dif.key = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(i[0] ? 1'b0 : 1'b1);
            check("rst_abcd",  int'({dif.a, dif.b, dif.c, dif.d}), 0);
            check("rst_ready", int'(dif.ready), 0);
            check("rst_error", int'(dif.error), 0);
        end
        reset   = 1'b0;
        dif.key = 1'b0;
        mon_en  = 1'b1;
        tick(1'b0);

        // Digit 7: dash 9, dash 9, dot 2 x3, then 15 lows.
        send_char(5'b11000, 2, 9, 15);

        for (int d = 0; d < 10; d++) send_char(pats[d], 2, 9, 15);

        // Threshold: 8 is a dash, 7 is a dot.
        send_char(5'b10000, 7, 8, 15);
        send_char(5'b01111, 7, 8, 15);

        // Back-to-back characters with no gap.
        send_char(5'b11100, 2, 9, 1);
        send_char(5'b00011, 2, 9, 15);

        // Partial character aborted at the 12th low.
        for (int s = 0; s < 3; s++) begin
            repeat (2) tick(1'b1);
            if (s < 2) repeat (3) tick(1'b0);
        end
        repeat (11) tick(1'b0);
        tick(1'b0);
        expect_pulse(1'b0, last_good);
        repeat (20) tick(1'b0);
        check("abort_held", int'({dif.a, dif.b, dif.c, dif.d}), int'(last_good));
        send_char(5'b00000, 2, 9, 15);
        check("after_abort", int'({dif.a, dif.b, dif.c, dif.d}), 5);

        // Invalid pattern leaves digit untouched.
        send_char(5'b01010, 2, 9, 15);
        check("invalid_held", int'({dif.a, dif.b, dif.c, dif.d}), 5);

        // Reset after two symbols, mid-mark.
        repeat (2) tick(1'b1);
        repeat (3) tick(1'b0);
        repeat (9) tick(1'b1);
        repeat (3) tick(1'b0);
        repeat (4) tick(1'b1);
        reset = 1'b1;
        tick(1'b1);
        tick(1'b0);
        reset = 1'b0;
        last_good = 4'd0;
        check("midrst_abcd",  int'({dif.a, dif.b, dif.c, dif.d}), 0);
        check("midrst_ready", int'(dif.ready), 0);
        check("midrst_error", int'(dif.error), 0);
        tick(1'b0);
        send_char(5'b11111, 2, 9, 15);
        check("final_digit", int'({dif.a, dif.b, dif.c, dif.d}), 0);

        repeat (20) tick(1'b0);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decodificador.md
# decodificador

Morse-to-binary digit decoder, the receive-side counterpart of `codificador`. It samples a single keyed line (`key`), times each mark to classify it as dot or dash, and collects the five symbols of a Morse digit. It then drives the 4-bit digit on `a`,`b`,`c`,`d` (same bit order as the `codificador` inputs) with a one-cycle `ready` strobe. Malformed characters raise `error` instead of `ready`.

## Interface
- `DASH_MIN`, 8: a mark of ≥ DASH_MIN cycles is a dash; a shorter mark is a dot.
- `GAP_MIN`, 12: consecutive low cycles that abort a partial character.
- `CNT_W`, 8: width of the mark and space counters. Legal values satisfy 1 ≤ DASH_MIN < GAP_MIN ≤ 2^CNT_W−1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key`  in  1  keyed line; 1 = mark, 0 = space; synchronous to `clk`.
- `a`,`b`,`c`,`d`  out  1 each  decoded digit, `a` = MSB; held until the next good decode.
- `ready`  out  1  one-cycle pulse: a new digit is on `a`..`d`.
- `error`  out  1  one-cycle pulse: character rejected.

## Operation
- Symbol encoding: dot = 0, dash = 1. Symbols shift into a 5-bit pattern, first symbol at bit 4.
- Digit patterns:
  - 0=11111, 1=01111, 2=00111, 3=00011, 4=00001
  - 5=00000, 6=10000, 7=11000, 8=11100, 9=11110
- States:
  - IDLE (no symbols held)
  - MARK (key high, `mark_cnt` counting)
  - SPACE (key low, 1–4 symbols held, `space_cnt` counting)
- IDLE:
  - key=1 → MARK, mark_cnt=1.
  - key=0 → stay.
- MARK:
  - key=1 → mark_cnt+1, saturating at 2^CNT_W−1; a saturated mark is a dash.
  - key=0 → classify the mark (dash iff mark_cnt ≥ DASH_MIN), shift it in, increment sym_cnt.
  - If sym_cnt reaches 5: decode the pattern, clear sym_cnt, go to IDLE.
  - Otherwise: go to SPACE, space_cnt=1.
- SPACE:
  - key=1 → MARK, mark_cnt=1.
  - key=0 → space_cnt+1. On the edge where space_cnt reaches GAP_MIN: pulse `error`, discard symbols, go to IDLE.
- Decode:
  - Pattern in table → load `a`..`d`, pulse `ready`.
  - Pattern not in table → pulse `error`; `a`..`d` unchanged.
- `ready` and `error` are never asserted together.
- A long trailing gap after a completed character is silent: the module sits in IDLE.
- Reset mid-character discards partial symbols and counters; no pulse is produced.

## Timing
- Reset values: state IDLE, counters 0, pattern 0; `a`,`b`,`c`,`d`,`ready`,`error` = 0.
- A mark of N high samples yields mark_cnt = N at the edge that samples the following low.
- Decode latency: `ready` or `error` is registered at the same edge that samples the low ending the 5th mark. It is visible for exactly the following cycle.
- Abort: `error` is registered at the edge sampling the GAP_MIN-th consecutive low after a symbol.
- A mark may begin on the cycle immediately after a decode. No inter-character gap is required.
- If `key` is high when reset deasserts, that mark is timed from the first non-reset edge.
- `reset` has priority over all other inputs on the same edge.

## Structure
- Package `morse_pkg`:
  - DOT/DASH symbol constants.
  - The ten 5-bit digit patterns, shared with `codificador`.
  - State enum.
  - Default DASH_MIN/GAP_MIN.
- Sub-module `morse_pattern_lookup`: combinational, 5-bit pattern → 4-bit digit plus `hit` flag.
- The timing FSM, counters, and shift register stay in `decodificador`.

## Test plan
- Reset: hold `reset` 2 cycles with key toggling → all outputs 0, no pulses.
- Digit 7 with defaults, sent as high 9 / low 3 / high 9 / low 3 / high 2 / low 3 / high 2 / low 3 / high 2 / low → single `ready`, abcd=0111, `error` never set.
- Sweep 0–9 with 15-cycle gaps between characters → ten `ready` pulses, abcd=0000…1001 in order.
- Dot/dash threshold: marks of 8, 7, 7, 7, 7 cycles → abcd=0110 (6). Marks of 7, 8, 8, 8, 8 → 0001 (1).
- Partial character: three 2-cycle dots, then 12 low → `error` at the 12th low sample, abcd held. A following 5-dot character → 0101.
- Invalid pattern and reset: pattern dot-dash-dot-dash-dot → `error`, no `ready`. Then reset after 2 symbols of a new character, then 5 dashes → abcd=0000 with one `ready`.
